acq_buffer_ctrl: RTL

Single-clock controller that sequences a simple dual-port sample RAM (registered write port, 1-cycle registered read port, 2^ADDR_WIDTH words) as a triggered circular acquisition buffer. It captures a stream of samples, enforces a programmable pre-trigger depth, and completes the post-trigger fill. It then streams the whole buffer out, oldest sample first, over a valid/ready interface to the readout path. It sits between the ADC sample stream / trigger logic and the sample RAM.

---
 rtl/acq_buffer_ctrl.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/acq_buffer_ctrl.sv
// acq_buffer_ctrl: triggered circular acquisition buffer controller.
// Captures a sample stream into an external simple dual-port RAM around a
// trigger event (programmable pre-trigger depth), then streams the whole
// buffer out oldest-first over a valid/ready interface.
module acq_buffer_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] pretrig_len,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  trigger,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_LAST  = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic [2:0] {
        IDLE,
        PRE_FILL,
        ARMED,
        POST_FILL,
        READOUT
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] pre_len;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] wptr_inc;
    logic [ADDR_WIDTH-1:0] pre_cnt;
    logic [ADDR_WIDTH-1:0] post_cnt;
    logic [ADDR_WIDTH:0]   issue_cnt;
    logic [ADDR_WIDTH:0]   pop_cnt;
    logic [1:0]            fifo_cnt;
    logic [1:0]            occupancy;
    logic                  rd_pend;
    logic [DATA_WIDTH-1:0] slot0;
    logic [DATA_WIDTH-1:0] slot1;

    logic accept;
    logic start_acq;
    logic trig_hit;
    logic enter_read;
    logic issue;
    logic pop;
    logic push;
    logic last_pop;

    // The pointer after the current write is also the oldest sample once the fill completes.
    assign wptr_inc  = wptr + ADDR_ONE;
    // Words either already in the skid slots or still in flight from the RAM.
    assign occupancy = fifo_cnt + {1'b0, rd_pend};
    assign push      = rd_pend;
    assign out_valid = (fifo_cnt != 2'd0);
    assign out_data  = slot0;
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the per-cycle strobes that steer the datapath.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        start_acq  = 1'b0;
        trig_hit   = 1'b0;
        enter_read = 1'b0;
        issue      = 1'b0;
        pop        = 1'b0;
        last_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_acq  = 1'b1;
                    state_next = (pretrig_len == '0) ? ARMED : PRE_FILL;
                end
            end
            PRE_FILL: begin
                accept = sample_valid;
                if (sample_valid && ((pre_cnt + ADDR_ONE) == pre_len)) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                accept = sample_valid;
                if (sample_valid && trigger) begin
                    trig_hit = 1'b1;
                    if (pre_len == ADDR_MAX) begin
                        enter_read = 1'b1;
                        state_next = READOUT;
                    end else begin
                        state_next = POST_FILL;
                    end
                end
            end
            POST_FILL: begin
                accept = sample_valid;
                if (sample_valid && (post_cnt == ADDR_ONE)) begin
                    enter_read = 1'b1;
                    state_next = READOUT;
                end
            end
            READOUT: begin
                pop   = out_valid & out_ready;
                issue = (issue_cnt != CNT_DEPTH) &&
                        ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));
                if (pop && (pop_cnt == CNT_LAST)) begin
                    last_pop   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered RAM write port: an accepted sample appears on the port one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_din   <= '0;
            wptr      <= '0;
        end else begin
            ram_we <= accept;
            if (start_acq) begin
                wptr <= '0;
            end
            if (accept) begin
                ram_waddr <= wptr;
                ram_din   <= sample_data;
                wptr      <= wptr_inc;
            end
        end
    end

    // Pre/post trigger counting and the triggered/done status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_len   <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= last_pop;
            if (start_acq) begin
                pre_len  <= pretrig_len;
                pre_cnt  <= '0;
                post_cnt <= '0;
            end
            if ((state == PRE_FILL) && accept) begin
                pre_cnt <= pre_cnt + ADDR_ONE;
            end
            if (trig_hit) begin
                triggered <= 1'b1;
                // DEPTH-1-P is simply the bitwise complement of P.
                post_cnt  <= ~pre_len;
            end else if ((state == POST_FILL) && accept) begin
                post_cnt <= post_cnt - ADDR_ONE;
            end
            if (last_pop) begin
                triggered <= 1'b0;
            end
        end
    end

    // Readout: issue RAM reads ahead of the consumer into a 2-slot skid buffer so a
    // held-high out_ready sees one word per cycle despite the RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_raddr <= '0;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            rd_pend   <= 1'b0;
            fifo_cnt  <= 2'd0;
            slot0     <= '0;
            slot1     <= '0;
        end else if (enter_read) begin
            ram_raddr <= wptr_inc;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            rd_pend   <= 1'b0;
            fifo_cnt  <= 2'd0;
        end else begin
            rd_pend <= issue;
            if (issue) begin
                ram_raddr <= ram_raddr + ADDR_ONE;
                issue_cnt <= issue_cnt + CNT_ONE;
            end
            if (pop) begin
                pop_cnt <= pop_cnt + CNT_ONE;
            end
            case ({push, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) begin
                        slot0 <= ram_dout;
                    end else begin
                        slot1 <= ram_dout;
                    end
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    slot0    <= slot1;
                    fifo_cnt <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        slot0 <= ram_dout;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= ram_dout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
